lag_measure_sequencer: RTL

Sequences repeated input-lag measurements in the 27 MHz `clock` domain. Each flash-start pulse from the video side opens a measurement window, and the block counts 10 µs ticks until the light sensor's rising edge. It captures each sample, drops samples that time out, and after 2^LOG2_SAMPLES good samples publishes min/max/average for the display/reporting path. It sits between the start-flag crossing, the 10 µs tick divider and the result consumer, and replaces single-shot capture logic.

---
 rtl/lag_measure_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/lag_measure_sequencer.sv
// lag_measure_sequencer: sequences repeated input-lag measurements. Each start pulse opens a
// window that counts 10 us ticks until the light sensor rises. Good samples are accumulated and,
// after 2^LOG2_SAMPLES of them, min/max/average are published on result_*.
// Optional feature macro: LAG_SENSOR_DEBOUNCE_EN (sensor must stay high DEBOUNCE_CYCLES clocks).
module lag_measure_sequencer #(
    parameter int unsigned COUNT_WIDTH     = 17,
    parameter int unsigned LOG2_SAMPLES    = 4,
    parameter int unsigned TIMEOUT_TICKS   = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 27
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   run_i,
    input  logic                   start_pulse_i,
    input  logic                   tick_i,
    input  logic                   sensor_i,
    output logic                   busy_o,
    output logic                   sample_valid_o,
    output logic [COUNT_WIDTH-1:0] sample_value_o,
    output logic                   sample_timeout_o,
    output logic                   result_valid_o,
    output logic                   result_done_o,
    output logic [COUNT_WIDTH-1:0] result_min_o,
    output logic [COUNT_WIDTH-1:0] result_max_o,
    output logic [COUNT_WIDTH-1:0] result_avg_o
);

    localparam int unsigned SumWidth = COUNT_WIDTH + LOG2_SAMPLES;
    localparam logic [COUNT_WIDTH-1:0] TimeoutLast = COUNT_WIDTH'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StMeasure} state_e;

    state_e                  state_q, state_d;
    logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                    filt;
    logic                    sens_q;
    logic                    rise;
    logic                    capture;
    logic                    timeout;

    logic                    sample_valid_q;
    logic                    sample_timeout_q;
    logic [COUNT_WIDTH-1:0]  sample_value_q;
    logic                    result_valid_q;
    logic                    result_done_q;
    logic [COUNT_WIDTH-1:0]  result_min_q, result_max_q, result_avg_q;
    logic [SumWidth-1:0]     sum_q;
    logic [COUNT_WIDTH-1:0]  min_q, max_q;
    logic [LOG2_SAMPLES-1:0] samp_cnt_q;

    logic [SumWidth-1:0]     sum_next;
    logic [COUNT_WIDTH-1:0]  min_next, max_next;
    logic                    last_sample;

`ifdef LAG_SENSOR_DEBOUNCE_EN
    localparam int unsigned DebWidth = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [DebWidth-1:0] DebMax = DebWidth'(DEBOUNCE_CYCLES);

    logic [DebWidth-1:0] deb_cnt_q;

    // Count consecutive high clocks, saturating; any low clock restarts the count.
    always_ff @(posedge clock_i) begin
        if (reset_i || !sensor_i) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q != DebMax) begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end

    // Rise only after a full stable-high run; fall immediately with the raw sensor.
    assign filt = sensor_i && (deb_cnt_q == DebMax);
`else
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYCLES != 0);
    assign filt = sensor_i;
`endif

    // Previous filtered sensor level for rising-edge detection.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sens_q <= 1'b0;
        end else begin
            sens_q <= filt;
        end
    end

    assign rise = filt & ~sens_q;

    // State register and window tick counter.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: a sensor edge beats both restart and timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (run_i) state_d = StArmed;
            end
            StArmed: begin
                if (start_pulse_i && !filt) begin
                    state_d = StMeasure;
                    cnt_d   = '0;
                end
            end
            StMeasure: begin
                if (rise) begin
                    cnt_d = '0;
                    if (!start_pulse_i) state_d = StArmed;
                end else if (start_pulse_i) begin
                    cnt_d = '0;
                end else if (tick_i) begin
                    if (cnt_q == TimeoutLast) begin
                        state_d = StArmed;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (!run_i) state_d = StIdle;
    end

    // Output decode: busy straight from the state, capture/timeout events for the datapath.
    always_comb begin
        busy_o  = (state_q != StIdle);
        capture = 1'b0;
        timeout = 1'b0;
        if (state_q == StMeasure && run_i) begin
            if (rise) begin
                capture = 1'b1;
            end else if (start_pulse_i || (tick_i && cnt_q == TimeoutLast)) begin
                timeout = 1'b1;
            end
        end
    end

    assign sum_next    = sum_q + SumWidth'(sample_value_q);
    assign min_next    = (sample_value_q < min_q) ? sample_value_q : min_q;
    assign max_next    = (sample_value_q > max_q) ? sample_value_q : max_q;
    assign last_sample = &samp_cnt_q;

    // Sample pulses at N+1, accumulation at N+1, round results visible at N+2.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sample_valid_q   <= 1'b0;
            sample_timeout_q <= 1'b0;
            sample_value_q   <= '0;
            result_valid_q   <= 1'b0;
            result_done_q    <= 1'b0;
            result_min_q     <= '0;
            result_max_q     <= '0;
            result_avg_q     <= '0;
            sum_q            <= '0;
            min_q            <= '1;
            max_q            <= '0;
            samp_cnt_q       <= '0;
        end else begin
            sample_valid_q   <= capture;
            sample_timeout_q <= timeout;
            result_done_q    <= 1'b0;
            if (capture) sample_value_q <= cnt_q;
            if (state_q == StIdle) begin
                sum_q      <= '0;
                min_q      <= '1;
                max_q      <= '0;
                samp_cnt_q <= '0;
            end else if (sample_valid_q && run_i) begin
                if (last_sample) begin
                    result_min_q   <= min_next;
                    result_max_q   <= max_next;
                    result_avg_q   <= COUNT_WIDTH'(sum_next >> LOG2_SAMPLES);
                    result_valid_q <= 1'b1;
                    result_done_q  <= 1'b1;
                    sum_q          <= '0;
                    min_q          <= '1;
                    max_q          <= '0;
                    samp_cnt_q     <= '0;
                end else begin
                    sum_q      <= sum_next;
                    min_q      <= min_next;
                    max_q      <= max_next;
                    samp_cnt_q <= samp_cnt_q + 1'b1;
                end
            end
        end
    end

    assign sample_valid_o   = sample_valid_q;
    assign sample_timeout_o = sample_timeout_q;
    assign sample_value_o   = sample_value_q;
    assign result_valid_o   = result_valid_q;
    assign result_done_o    = result_done_q;
    assign result_min_o     = result_min_q;
    assign result_max_o     = result_max_q;
    assign result_avg_o     = result_avg_q;

endmodule
